// File: rtl/univ_register_if.sv
// Bus bundle for the universal register: control/data inputs and q/flag outputs.
// The master drives the operation; the slave (the register) returns its state.
interface univ_register_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_lsb;
   logic             sin_msb;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic             carry;
   logic             zero;

   modport master (
      output en, mode, d, sin_lsb, sin_msb,
      input  q, qbar, carry, zero
   );

   modport slave (
      input  en, mode, d, sin_lsb, sin_msb,
      output q, qbar, carry, zero
   );
endinterface

// File: rtl/univ_register.sv
// Parametrised universal register: load, shift, rotate, increment and decrement
// with a registered carry flag, plus combinational qbar and zero outputs.
module univ_register #(
   parameter int unsigned       WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input logic               clk,
   input logic               rst,
   univ_register_if.slave    bus
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic             carry_q, carry_d;
   logic [WIDTH:0]   inc_sum;
   logic [WIDTH:0]   dec_diff;

   // Extra top bit captures the wrap: carry-out on INC, borrow on DEC.
   assign inc_sum  = {1'b0, q_q} + (WIDTH+1)'(1);
   assign dec_diff = {1'b0, q_q} - (WIDTH+1)'(1);

   // Next-state selection; en=0 falls through to hold.
   always_comb begin
      q_d     = q_q;
      carry_d = carry_q;
      if (bus.en) begin
         case (mode_e'(bus.mode))
            MODE_HOLD: begin
               q_d     = q_q;
               carry_d = carry_q;
            end
            MODE_LOAD: begin
               q_d     = bus.d;
               carry_d = 1'b0;
            end
            MODE_SHL: begin
               q_d     = {q_q[WIDTH-2:0], bus.sin_lsb};
               carry_d = q_q[WIDTH-1];
            end
            MODE_SHR: begin
               q_d     = {bus.sin_msb, q_q[WIDTH-1:1]};
               carry_d = q_q[0];
            end
            MODE_ROL: begin
               q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               carry_d = q_q[WIDTH-1];
            end
            MODE_ROR: begin
               q_d     = {q_q[0], q_q[WIDTH-1:1]};
               carry_d = q_q[0];
            end
            MODE_INC: begin
               q_d     = inc_sum[WIDTH-1:0];
               carry_d = inc_sum[WIDTH];
            end
            MODE_DEC: begin
               q_d     = dec_diff[WIDTH-1:0];
               carry_d = dec_diff[WIDTH];
            end
            default: begin
               q_d     = q_q;
               carry_d = carry_q;
            end
         endcase
      end
   end

   // Synchronous active-low reset overrides enable and mode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q     <= RESET_VALUE;
         carry_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         carry_q <= carry_d;
      end
   end

   assign bus.q     = q_q;
   assign bus.qbar  = ~q_q;
   assign bus.carry = carry_q;
   assign bus.zero  = (q_q == '0);

endmodule

// File: tb/tb_univ_register.sv
// Scoreboard bench for univ_register (WIDTH=8, RESET_VALUE=8'hA5): directed
// operations queue their expected q/carry; a monitor compares after each edge.
module tb_univ_register;

   localparam int unsigned WIDTH = 8;

   typedef struct {
      int         tag;
      logic [7:0] q;
      logic       c;
   } exp_t;

   logic clk;
   logic rst;
   int   edge_no;
   int   checks;
   int   errors;
   exp_t sb[$];

   univ_register_if #(.WIDTH(WIDTH)) bus ();

   univ_register #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (8'hA5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one cycle of stimulus and, when asked, queue the post-edge expectation.
   task automatic step(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] dd, input logic sl, input logic sm,
                       input bit chk, input logic [7:0] eq, input logic ec);
      exp_t item;
      @(negedge clk);
      rst         = r;
      bus.en      = e;
      bus.mode    = m;
      bus.d       = dd;
      bus.sin_lsb = sl;
      bus.sin_msb = sm;
      if (chk) begin
         item.tag = edge_no + 1;
         item.q   = eq;
         item.c   = ec;
         sb.push_back(item);
      end
   endtask

   task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @edge %0d: got %h expected %h", name, edge_no, act, req);
      end
   endtask

   task automatic cmp1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @edge %0d: got %b expected %b", name, edge_no, act, req);
      end
   endtask

   // Monitor: after every edge, pop and compare expectations tagged for it.
   initial begin
      exp_t item;
      edge_no = 0;
      forever begin
         @(posedge clk);
         edge_no++;
         #1;
         while (sb.size() > 0 && sb[0].tag <= edge_no) begin
            item = sb.pop_front();
            if (item.tag < edge_no) begin
               checks++;
               errors++;
               $display("FAIL missed_check: tag %0d seen at edge %0d", item.tag, edge_no);
            end else begin
               cmp8("q", bus.q, item.q);
               cmp1("carry", bus.carry, item.c);
               cmp8("qbar", bus.qbar, ~item.q);
               cmp1("zero", bus.zero, (item.q == 8'h00));
            end
         end
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b0;
      bus.en      = 1'b0;
      bus.mode    = 3'b000;
      bus.d       = 8'h00;
      bus.sin_lsb = 1'b0;
      bus.sin_msb = 1'b0;

      // Reset with en=0, then hold despite a pending LOAD
      step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
      repeat (3) step(1'b1, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);

      // Load and shift
      step(1'b1, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0);
      step(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1);
      step(1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0);

      // Rotate
      step(1'b1, 1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
      step(1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
      step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         logic [7:0] eq;
         eq = (i == 8) ? 8'h01 : 8'(1 << i);
         step(1'b1, 1'b1, 3'b100, 8'h00, 1'b1, 1'b1, 1'b1, eq, (i == 8));
      end

      // Wrap-around, with a HOLD that must keep carry
      step(1'b1, 1'b1, 3'b001, 8'hFE, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);
      step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
      step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      step(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
      step(1'b1, 1'b1, 3'b000, 8'h33, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
      step(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);

      // Enable gating
      step(1'b1, 1'b1, 3'b001, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
      repeat (4) step(1'b1, 1'b0, 3'b110, 8'h77, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0);
      step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);

      // Reset mid-count, then resume from RESET_VALUE
      step(1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 1; i <= 5; i++)
         step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
      step(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
      step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA6, 1'b0);

      // Drain the scoreboard within a bounded number of edges
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/univ_register.md
Name: univ_register

Overview:
- Parametrised universal register, the next-generation successor of the single-bit D flip-flop in the CPU datapath.
- Generalises the flip-flop to WIDTH bits. Adds clock enable, load, shift, rotate, increment and decrement modes, a carry flag and a zero flag.
- Used for the accumulator, shift and counter registers of the CPU. Keeps the complementary q/qbar outputs of the flip-flop.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RESET_VALUE, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (rst=0 resets on the next rising clk edge).
- en  input  1  clock enable; 0 holds q and carry unconditionally.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin_lsb  input  1  serial input shifted into bit 0 on SHL.
- sin_msb  input  1  serial input shifted into bit WIDTH-1 on SHR.
- q  output  WIDTH  registered value.
- qbar  output  WIDTH  bitwise complement of q (combinational from q).
- carry  output  1  registered carry/shift-out/borrow flag.
- zero  output  1  combinational; 1 when q equals 0.

Behaviour:
- Reset, rising edge with rst=0:
  - q <= RESET_VALUE, carry <= 0.
  - Has priority over en and mode.
  - During reset, qbar = ~RESET_VALUE and zero = (RESET_VALUE == 0).
- Before the first reset edge, q and carry are X. The bench must not check them.
- en=0 with rst=1: q and carry hold; mode, d and the serial inputs are ignored.
- en=1 with rst=1: the operation below completes in 1 cycle; the result is visible after the edge.
  - 000 HOLD: q unchanged, carry unchanged.
  - 001 LOAD: q <= d, carry <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_lsb}, carry <= q[WIDTH-1].
  - 011 SHR: q <= {sin_msb, q[WIDTH-1:1]}, carry <= q[0].
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}, carry <= q[WIDTH-1].
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}, carry <= q[0].
  - 110 INC: q <= q+1 modulo 2^WIDTH, carry <= 1 only when q was all ones (wrap to 0), else 0.
  - 111 DEC: q <= q-1 modulo 2^WIDTH, carry <= 1 only when q was 0 (wrap to all ones), else 0.
- Arithmetic is unsigned. No saturation: wrap-around is the required behaviour.
- All operations read pre-edge q. Back-to-back operations chain with no bubble.
- Reset mid-sequence (for example during INC counting): the next edge with rst=0 overrides the operation. The operation issued on the first edge after rst returns to 1 acts on RESET_VALUE.
- rst=0 together with en=0: reset still takes effect.
- mode, d, sin_lsb and sin_msb are sampled only at the clock edge. Glitches between edges have no effect.
- qbar and zero track q combinationally with no added latency.

Test Plan (WIDTH=8, RESET_VALUE=8'hA5):
- Reset: hold rst=0 for 1 edge, then rst=1, en=0 -> q=8'hA5, qbar=8'h5A, carry=0, zero=0; holds for 3 cycles despite mode=001, d=8'hFF.
- Load and shift: LOAD d=8'h81; SHL sin_lsb=0 -> q=8'h02, carry=1; SHR sin_msb=1 -> q=8'h81, carry=0.
- Rotate: LOAD 8'h01; ROR -> q=8'h80, carry=1; ROL -> q=8'h01, carry=1; 8 consecutive ROL -> q=8'h01.
- Wrap-around: LOAD 8'hFE; INC -> q=8'hFF, carry=0; INC -> q=8'h00, carry=1, zero=1; DEC -> q=8'hFF, carry=1; DEC -> q=8'hFE, carry=0.
- Enable gating: LOAD 8'h10, then en=0 with mode=110 for 4 cycles -> q=8'h10; en=1 for 1 cycle -> q=8'h11.
- Reset mid-count: INC from 8'h00 for 5 cycles, assert rst=0 on the 6th edge -> q=8'hA5, carry=0; release rst, 1 INC -> q=8'hA6.
